tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001: Parameter NUM_CH, default 4, number of time slots/output channels per frame (2..16).
REQ-002: Parameter SLOT_W, default 8, bits per slot (1..16).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: bit_en  input  1  qualifies din/frame_sync; sampled only when high.
REQ-006: din  input  1  serial TDM data, MSB of each slot first.
REQ-007: frame_sync  input  1  high on the bit_en cycle carrying bit 0 (MSB) of slot 0.
REQ-008: ch_data  output  NUM_CH*SLOT_W  held per-channel words; slot k at bits [k*SLOT_W +: SLOT_W].
REQ-009: ch_stb  output  1  one-cycle pulse when a slot word is written.
REQ-010: ch_idx  output  $clog2(NUM_CH)  slot index written on ch_stb.
REQ-011: frame_done  output  1  one-cycle pulse, coincident with ch_stb for slot NUM_CH-1.
REQ-012: locked  output  1  high while in SYNC state.
REQ-013: sync_err  output  1  one-cycle pulse on framing error.

Function
REQ-014: FSM states HUNT and SYNC; cycles with bit_en low change no state and drive all pulses low.
REQ-015: HUNT: bit_en & frame_sync -> shift din as bit 0 of slot 0, go SYNC; otherwise remain, discard din.
REQ-016: SYNC: each bit_en cycle shifts din into slot shift register; bit counter 0..SLOT_W-1, slot counter 0..NUM_CH-1, both wrap to 0.
REQ-017: On sampling bit SLOT_W-1 of slot k: next edge writes ch_data slot k, ch_stb=1, ch_idx=k (latency 1 clk from last sample).
REQ-018: Other slots of ch_data hold their values; ch_idx holds last value when ch_stb low.
REQ-019: frame_sync high in SYNC at a position other than slot 0/bit 0: sync_err pulse, partial slot discarded (no ch_stb), counters restart with that bit as slot 0/bit 0, stay SYNC.
REQ-020: frame_sync low at expected slot 0/bit 0 in SYNC: sync_err pulse, go HUNT, that bit discarded.
REQ-021: frame_sync at expected slot 0/bit 0: no error, normal operation.
REQ-022: Frame-end strobe and sync_err never coincide for the same sample; completed-slot write takes precedence over nothing (completed slots already written stay).

Reset
REQ-023: rst high at clock edge: state HUNT, counters 0, shift register 0, ch_data 0, ch_stb/frame_done/sync_err 0, ch_idx 0, locked 0.
REQ-024: rst mid-frame abandons the partial slot; no strobe issued; rst dominates bit_en.

Configuration
REQ-025: Macro TDM_DEMUX_ERRCNT_EN defined: output err_cnt (8 bits) counts sync_err pulses, saturates at 255, cleared only by rst.
REQ-026: Macro undefined: err_cnt port and counter absent; all other behaviour identical.

Structure
REQ-027: Package tdm_pkg holds the FSM state enum (HUNT, SYNC) and default constants NUM_CH_DEF=4, SLOT_W_DEF=8.
REQ-028: Sub-module tdm_deser (SLOT_W shift register plus bit counter, slot_done output) instantiated once; FSM, slot counter and output registers live in tdm_demux.

Verification
REQ-029: Defaults, bit_en=1, four clean frames with slots 0xA5,0x3C,0xFF,0x01 -> ch_stb with ch_idx 0..3 one clk after each slot's last bit, ch_data=0x01FF3CA5, frame_done with idx 3, locked=1 from first sync.
REQ-030: Same frame with bit_en toggling 1/0 every cycle -> identical ch_data/strobe sequence, pulses only one clk wide, none on stalled cycles.
REQ-031: frame_sync asserted at slot 2 bit 3 -> sync_err pulse, no strobe for slot 2, next 0x5A serial data captured into slot 0.
REQ-032: frame_sync absent at frame boundary -> sync_err, locked falls, no strobes until next frame_sync, then relock.
REQ-033: rst asserted at slot 1 bit 4 -> all outputs 0 next clk, locked 0, no ch_stb.
REQ-034: With TDM_DEMUX_ERRCNT_EN, 300 forced misaligned syncs -> err_cnt=255; rst -> 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } tdm_state_e;

  localparam int NUM_CH_DEF = 4;
  localparam int SLOT_W_DEF = 8;

endpackage

// File: rtl/tdm_deser.sv
// Slot deserializer: MSB-first shift register with a bit counter that flags
// the sample completing a slot word.
module tdm_deser
  import tdm_pkg::*;
#(
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic              din_i,
  output logic [SLOT_W-1:0] word_o,
  output logic              slot_done_o,
  output logic              at_bit0_o
);

  localparam int CNT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  logic [SLOT_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  eff_cnt;
  logic [SLOT_W:0]   ext;

  // A start sample begins a fresh word, so stale partial bits never leak in.
  assign ext         = {sr_q, din_i};
  assign eff_cnt     = start_i ? '0 : cnt_q;
  assign word_o      = start_i ? SLOT_W'(din_i) : ext[SLOT_W-1:0];
  assign slot_done_o = shift_i && (eff_cnt == CNT_W'(SLOT_W - 1));
  assign at_bit0_o   = (cnt_q == '0);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = word_o;
      cnt_d = slot_done_o ? '0 : eff_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM serial-to-parallel demultiplexer with frame-sync tracking.
// Optional TDM_DEMUX_ERRCNT_EN adds a saturating 8-bit sync error counter.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       din,
  input  logic                       frame_sync,
  output logic [NUM_CH*SLOT_W-1:0]   ch_data,
  output logic                       ch_stb,
  output logic [$clog2(NUM_CH)-1:0]  ch_idx,
  output logic                       frame_done,
  output logic                       locked,
  output logic                       sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_CH - 1);

  tdm_state_e                state_q, state_d;
  logic [IDX_W-1:0]          slot_q, slot_d, slot_cur;
  logic [NUM_CH*SLOT_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      stb_q, stb_d;
  logic                      fd_q, fd_d;
  logic                      err_q, err_d;

  logic                      shift, start, clr;
  logic [SLOT_W-1:0]         word;
  logic                      slot_done, at_bit0, at_start;

  tdm_deser #(.SLOT_W(SLOT_W)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .shift_i    (shift),
    .start_i    (start),
    .clr_i      (clr),
    .din_i      (din),
    .word_o     (word),
    .slot_done_o(slot_done),
    .at_bit0_o  (at_bit0)
  );

  assign at_start = at_bit0 && (slot_q == '0);

  // Framing decisions; a misplaced sync restarts the frame on that very bit.
  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
    err_d   = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shift   = 1'b1;
            start   = 1'b1;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (frame_sync && !at_start) begin
            err_d = 1'b1;
            shift = 1'b1;
            start = 1'b1;
          end else if (!frame_sync && at_start) begin
            err_d   = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            shift = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    slot_cur = start ? '0 : slot_q;
    slot_d   = slot_q;
    data_d   = data_q;
    idx_d    = idx_q;
    stb_d    = 1'b0;
    fd_d     = 1'b0;
    if (clr) begin
      slot_d = '0;
    end else if (slot_done) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot_cur == IDX_W'(k)) data_d[k*SLOT_W +: SLOT_W] = word;
      end
      stb_d  = 1'b1;
      idx_d  = slot_cur;
      fd_d   = (slot_cur == LAST_SLOT);
      slot_d = (slot_cur == LAST_SLOT) ? '0 : slot_cur + IDX_W'(1);
    end else if (start) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign ch_data    = data_q;
  assign ch_stb     = stb_q;
  assign ch_idx     = idx_q;
  assign frame_done = fd_q;
  assign sync_err   = err_q;
  assign locked     = (state_q == SYNC);

endmodule
